// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
//   arb_state_e - arbiter sequencing state (idle, read response due, write commit)
//   REQ_FETCH / REQ_DATA - requester indices into the [1:0] request vectors
//   arb_req_t   - one requester's transaction fields, gathered for muxing
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR
    } arb_state_e;

    localparam int unsigned REQ_FETCH  = 0;
    localparam int unsigned REQ_DATA   = 1;
    localparam int unsigned ARB_ADDR_W = 32;

    typedef struct packed {
        logic                  we;
        logic [1:0]            acc;
        logic                  sext;
        logic [ARB_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
    } arb_req_t;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational 2-way round-robin select.
//   req_i    - request valid per port (bit 0 = fetch, bit 1 = data)
//   last_i   - index of the port granted most recently
//   winner_o - selected port index (meaningful only when valid_o)
//   valid_o  - at least one port is requesting
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       winner_o,
    output logic       valid_o
);

    always_comb begin
        valid_o  = |req_i;
        winner_o = 1'(REQ_FETCH);
        // Data wins when it is alone, or on contention when fetch went last.
        if (req_i[REQ_DATA] && (!req_i[REQ_FETCH] || (last_i == 1'(REQ_FETCH)))) begin
            winner_o = 1'(REQ_DATA);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one mem_control between instruction fetch (port 0) and data
// load/store (port 1). Round-robin arbitration; reads pipeline one per cycle with a
// fixed one-cycle response, writes take a grant cycle plus a commit cycle.
// The instantiating level ties mem_control.rstn_i to ~rst_i.
//   clk_i, rst_i        - clock, synchronous active-high reset
//   req_i/we_i/acc_i/sext_i/addr_i/wdata_i - per-port request, held until granted
//   gnt_o               - one-hot (or zero) acceptance, combinational
//   rvalid_o, rdata_o   - read response to the owning port, one cycle after grant
//   mc_r_en_o, mc_sext_o, mc_acc_r_o, mc_addr_r_o, mc_data_r_i - memory read port
//   mc_wr_en_o, mc_acc_w_o, mc_addr_w_o, mc_data_w_o, mc_wr_ready_i - memory write port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ARB_ADDR_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             req_i,
    input  logic [1:0]             we_i,
    input  logic [1:0][1:0]        acc_i,
    input  logic [1:0]             sext_i,
    input  logic [1:0][ADDR_W-1:0] addr_i,
    input  logic [1:0][31:0]       wdata_i,
    output logic [1:0]             gnt_o,
    output logic [1:0]             rvalid_o,
    output logic [31:0]            rdata_o,
    output logic                   mc_r_en_o,
    output logic                   mc_sext_o,
    output logic [1:0]             mc_acc_r_o,
    output logic [ADDR_W-1:0]      mc_addr_r_o,
    input  logic [31:0]            mc_data_r_i,
    output logic                   mc_wr_en_o,
    output logic [1:0]             mc_acc_w_o,
    output logic [ADDR_W-1:0]      mc_addr_w_o,
    output logic [31:0]            mc_data_w_o,
    input  logic                   mc_wr_ready_i
);

    arb_state_e        state_q;
    logic              last_q;
    logic              rd_owner_q;
    logic [1:0]        hold_acc_q;
    logic [ADDR_W-1:0] hold_addr_q;
    logic [31:0]       hold_data_q;

    arb_req_t [1:0] rq;
    arb_req_t       sel;
    logic           win;
    logic           win_valid;
    logic           rd_gnt;
    logic           wr_gnt;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rq[i].we    = we_i[i];
            rq[i].acc   = acc_i[i];
            rq[i].sext  = sext_i[i];
            rq[i].addr  = ARB_ADDR_W'(addr_i[i]);
            rq[i].wdata = wdata_i[i];
        end
    end

    rr_pick2 u_pick (
        .req_i   (req_i),
        .last_i  (last_q),
        .winner_o(win),
        .valid_o (win_valid)
    );

    // Only the round-robin winner is considered; an ineligible winner blocks the
    // cycle rather than letting the loser through, so neither port can starve.
    always_comb begin
        sel    = rq[win];
        rd_gnt = 1'b0;
        wr_gnt = 1'b0;
        if (!rst_i && win_valid) begin
            if (!sel.we) begin
                rd_gnt = (state_q == S_IDLE) || (state_q == S_RD);
            end else begin
                wr_gnt = (state_q == S_IDLE) && mc_wr_ready_i;
            end
        end
    end

    always_comb begin
        gnt_o       = '0;
        rvalid_o    = '0;
        rdata_o     = '0;
        mc_r_en_o   = 1'b0;
        mc_sext_o   = 1'b0;
        mc_acc_r_o  = '0;
        mc_addr_r_o = '0;
        mc_wr_en_o  = 1'b0;
        mc_acc_w_o  = '0;
        mc_addr_w_o = '0;
        mc_data_w_o = '0;

        if (rd_gnt || wr_gnt) begin
            gnt_o[win] = 1'b1;
        end

        if (rd_gnt) begin
            mc_r_en_o   = 1'b1;
            mc_sext_o   = sel.sext;
            mc_acc_r_o  = sel.acc;
            mc_addr_r_o = ADDR_W'(sel.addr);
        end

        // Read enable stays high in the response cycle so mem_control presents data.
        if (!rst_i && (state_q == S_RD)) begin
            mc_r_en_o            = 1'b1;
            rvalid_o[rd_owner_q] = 1'b1;
            rdata_o              = mc_data_r_i;
        end

        if (wr_gnt) begin
            mc_wr_en_o  = 1'b1;
            mc_acc_w_o  = sel.acc;
            mc_addr_w_o = ADDR_W'(sel.addr);
            mc_data_w_o = sel.wdata;
        end else if (!rst_i && (state_q == S_WR)) begin
            mc_acc_w_o  = hold_acc_q;
            mc_addr_w_o = hold_addr_q;
            mc_data_w_o = hold_data_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            last_q      <= 1'(REQ_DATA);
            rd_owner_q  <= 1'(REQ_FETCH);
            hold_acc_q  <= '0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
        end else begin
            if (rd_gnt || wr_gnt) begin
                last_q <= win;
            end
            if (rd_gnt) begin
                rd_owner_q <= win;
            end
            if (wr_gnt) begin
                hold_acc_q  <= sel.acc;
                hold_addr_q <= ADDR_W'(sel.addr);
                hold_data_q <= sel.wdata;
            end
            unique case (state_q)
                S_IDLE, S_RD: begin
                    if (wr_gnt) begin
                        state_q <= S_WR;
                    end else if (rd_gnt) begin
                        state_q <= S_RD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WR:    state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed test-plan sequences followed by randomized traffic, all
// checked cycle by cycle against a transaction-level model with its own memory image.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned MEM_BYTES = 256;
    localparam logic [1:0]  ACC_BYTE  = 2'd0;
    localparam logic [1:0]  ACC_HALF  = 2'd1;
    localparam logic [1:0]  ACC_WORD  = 2'd2;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [1:0]             req_i;
    logic [1:0]             we_i;
    logic [1:0][1:0]        acc_i;
    logic [1:0]             sext_i;
    logic [1:0][ADDR_W-1:0] addr_i;
    logic [1:0][31:0]       wdata_i;
    logic [1:0]             gnt_o;
    logic [1:0]             rvalid_o;
    logic [31:0]            rdata_o;
    logic                   mc_r_en_o;
    logic                   mc_sext_o;
    logic [1:0]             mc_acc_r_o;
    logic [ADDR_W-1:0]      mc_addr_r_o;
    logic [31:0]            mc_data_r_i = 32'h0;
    logic                   mc_wr_en_o;
    logic [1:0]             mc_acc_w_o;
    logic [ADDR_W-1:0]      mc_addr_w_o;
    logic [31:0]            mc_data_w_o;
    logic                   mc_wr_ready_i;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .we_i         (we_i),
        .acc_i        (acc_i),
        .sext_i       (sext_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .mc_r_en_o    (mc_r_en_o),
        .mc_sext_o    (mc_sext_o),
        .mc_acc_r_o   (mc_acc_r_o),
        .mc_addr_r_o  (mc_addr_r_o),
        .mc_data_r_i  (mc_data_r_i),
        .mc_wr_en_o   (mc_wr_en_o),
        .mc_acc_w_o   (mc_acc_w_o),
        .mc_addr_w_o  (mc_addr_w_o),
        .mc_data_w_o  (mc_data_w_o),
        .mc_wr_ready_i(mc_wr_ready_i)
    );

    logic [7:0] mem     [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];
    logic       mem_init = 1'b0;

    function automatic logic [7:0] init_byte(input int k);
        logic [31:0] w;
        case (k / 4)
            4:       w = 32'h11223344;
            8:       w = 32'h12345678;
            12:      w = 32'h80FF7F00;
            default: w = (32'(k) * 32'h01030507) ^ 32'h5A3C96E1;
        endcase
        return w[8*(k%4) +: 8];
    endfunction

    function automatic int nbytes(input logic [1:0] acc);
        return (acc == ACC_BYTE) ? 1 : (acc == ACC_HALF) ? 2 : 4;
    endfunction

    // Little-endian load with optional sign extension; out-of-range reads give 0.
    function automatic logic [31:0] mem_rd(input bit use_ref, input logic [31:0] a,
                                           input logic [1:0] acc, input logic sext);
        logic [31:0] w;
        if (a >= MEM_BYTES) return 32'h0;
        for (int i = 0; i < 4; i++) begin
            w[8*i +: 8] = use_ref ? ref_mem[(int'(a) + i) % MEM_BYTES]
                                  : mem[(int'(a) + i) % MEM_BYTES];
        end
        case (acc)
            ACC_BYTE: return sext ? {{24{w[7]}}, w[7:0]} : {24'h0, w[7:0]};
            ACC_HALF: return sext ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
            default:  return w;
        endcase
    endfunction

    // Stand-in for mem_control: registered read data, write on the enable cycle.
    always @(posedge clk_i) begin
        if (!mem_init) begin
            for (int k = 0; k < MEM_BYTES; k++) mem[k] = init_byte(k);
            mem_init = 1'b1;
        end
        if (mc_wr_en_o && (mc_addr_w_o < MEM_BYTES)) begin
            for (int i = 0; i < nbytes(mc_acc_w_o); i++) begin
                mem[(int'(mc_addr_w_o) + i) % MEM_BYTES] = mc_data_w_o[8*i +: 8];
            end
        end
        mc_data_r_i <= mc_r_en_o ? mem_rd(1'b0, mc_addr_r_o, mc_acc_r_o, mc_sext_o) : 32'h0;
    end

    // Reference model: pending read responses, write-commit blocking, round-robin pointer.
    typedef struct packed {
        logic [1:0]  oh;
        logic [31:0] data;
    } rsp_t;

    rsp_t        rsp_q[$];
    bit          m_last;
    bit          m_wr_block;
    logic [1:0]  m_hold_acc;
    logic [31:0] m_hold_addr;
    logic [31:0] m_hold_data;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [1:0]  obs_gnt;
    logic [1:0]  obs_rvalid;
    logic [31:0] obs_rdata;
    logic        obs_wr_en;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic put(input int p, input bit a, input bit we, input logic [1:0] acc,
                       input bit sx, input logic [31:0] ad, input logic [31:0] wd);
        req_i[p]   = a;
        we_i[p]    = we;
        acc_i[p]   = acc;
        sext_i[p]  = sx;
        addr_i[p]  = ad;
        wdata_i[p] = wd;
    endtask

    // One clock cycle: compare DUT outputs to the model at negedge, advance the model.
    task automatic step();
        logic [1:0]  e_gnt, e_rvalid, e_acc_r, e_acc_w;
        logic [31:0] e_rdata, e_addr_r, e_addr_w, e_data_w;
        logic        e_r_en, e_sext, e_wr_en;
        bit          w, ok, nxt_block;
        rsp_t        r;
        @(negedge clk_i);
        obs_gnt    = gnt_o;
        obs_rvalid = rvalid_o;
        obs_rdata  = rdata_o;
        obs_wr_en  = mc_wr_en_o;
        {e_gnt, e_rvalid, e_acc_r, e_acc_w} = '0;
        {e_rdata, e_addr_r, e_addr_w, e_data_w} = '0;
        {e_r_en, e_sext, e_wr_en} = '0;
        if (rst_i) begin
            rsp_q.delete();
            m_last     = 1'b1;
            m_wr_block = 1'b0;
        end else begin
            w  = (req_i == 2'b11) ? ~m_last : req_i[1];
            ok = 1'b0;
            if ((req_i != 2'b00) && !m_wr_block) begin
                ok = we_i[w] ? ((rsp_q.size() == 0) && mc_wr_ready_i) : 1'b1;
            end
            if (rsp_q.size() > 0) begin
                r        = rsp_q.pop_front();
                e_rvalid = r.oh;
                e_rdata  = r.data;
                e_r_en   = 1'b1;
            end
            if (m_wr_block) begin
                e_acc_w  = m_hold_acc;
                e_addr_w = m_hold_addr;
                e_data_w = m_hold_data;
            end
            nxt_block = 1'b0;
            if (ok) begin
                e_gnt  = w ? 2'b10 : 2'b01;
                m_last = w;
                if (we_i[w]) begin
                    e_wr_en     = 1'b1;
                    e_acc_w     = acc_i[w];
                    e_addr_w    = addr_i[w];
                    e_data_w    = wdata_i[w];
                    m_hold_acc  = acc_i[w];
                    m_hold_addr = addr_i[w];
                    m_hold_data = wdata_i[w];
                    nxt_block   = 1'b1;
                    if (addr_i[w] < MEM_BYTES) begin
                        for (int i = 0; i < nbytes(acc_i[w]); i++) begin
                            ref_mem[(int'(addr_i[w]) + i) % MEM_BYTES] = wdata_i[w][8*i +: 8];
                        end
                    end
                end else begin
                    e_r_en   = 1'b1;
                    e_sext   = sext_i[w];
                    e_acc_r  = acc_i[w];
                    e_addr_r = addr_i[w];
                    rsp_q.push_back({e_gnt, mem_rd(1'b1, addr_i[w], acc_i[w], sext_i[w])});
                end
            end
            m_wr_block = nxt_block;
        end
        check("gnt", gnt_o, e_gnt);
        check("rvalid", rvalid_o, e_rvalid);
        check("rdata", rdata_o, e_rdata);
        check("r_en", mc_r_en_o, e_r_en);
        check("sext", mc_sext_o, e_sext);
        check("acc_r", mc_acc_r_o, e_acc_r);
        check("addr_r", mc_addr_r_o, e_addr_r);
        check("wr_en", mc_wr_en_o, e_wr_en);
        check("acc_w", mc_acc_w_o, e_acc_w);
        check("addr_w", mc_addr_w_o, e_addr_w);
        check("data_w", mc_data_w_o, e_data_w);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [1:0]  acc;
        logic [31:0] ad;
        for (int k = 0; k < MEM_BYTES; k++) ref_mem[k] = init_byte(k);
        m_last = 1'b1;
        m_wr_block = 1'b0;
        {m_hold_acc, m_hold_addr, m_hold_data} = '0;
        rst_i = 1'b1;
        mc_wr_ready_i = 1'b1;
        put(0, 0, 0, ACC_WORD, 0, 32'h0, 32'h0);
        put(1, 0, 0, ACC_WORD, 0, 32'h0, 32'h0);
        step();
        step();
        rst_i = 1'b0;

        // Single word read by fetch.
        put(0, 1, 0, ACC_WORD, 0, 32'h10, 32'h0);
        step();
        check("rd1_gnt", obs_gnt, 2'b01);
        put(0, 0, 0, ACC_WORD, 0, 32'h10, 32'h0);
        step();
        check("rd1_rvalid", obs_rvalid, 2'b01);
        check("rd1_rdata", obs_rdata, 32'h11223344);

        // Back-to-back sign-extended byte reads by data port.
        put(1, 1, 0, ACC_BYTE, 1, 32'h31, 32'h0);
        step();
        check("b2b_gnt0", obs_gnt, 2'b10);
        put(1, 1, 0, ACC_BYTE, 1, 32'h33, 32'h0);
        step();
        check("b2b_gnt1", obs_gnt, 2'b10);
        check("b2b_rdata0", obs_rdata, 32'h0000007F);
        put(1, 0, 0, ACC_BYTE, 1, 32'h33, 32'h0);
        step();
        check("b2b_rvalid1", obs_rvalid, 2'b10);
        check("b2b_rdata1", obs_rdata, 32'hFFFFFF80);

        // Halfword write, blocked cycle, then readback of the merged word.
        put(1, 1, 1, ACC_HALF, 0, 32'h22, 32'h0000BEEF);
        step();
        check("wr_gnt", obs_gnt, 2'b10);
        check("wr_en_n", obs_wr_en, 1'b1);
        put(1, 0, 0, ACC_HALF, 0, 32'h22, 32'h0);
        put(0, 1, 0, ACC_WORD, 0, 32'h20, 32'h0);
        step();
        check("wr_gnt_n1", obs_gnt, 2'b00);
        check("wr_en_n1", obs_wr_en, 1'b0);
        step();
        check("wrrd_gnt", obs_gnt, 2'b01);
        put(0, 0, 0, ACC_WORD, 0, 32'h20, 32'h0);
        step();
        check("wrrd_rdata", obs_rdata, 32'hBEEF5678);

        // Reset during the write commit cycle, then during a read response cycle.
        put(1, 1, 1, ACC_WORD, 0, 32'h40, 32'hCAFEF00D);
        step();
        put(1, 0, 1, ACC_WORD, 0, 32'h40, 32'h0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        put(0, 1, 0, ACC_WORD, 0, 32'h10, 32'h0);
        put(1, 1, 0, ACC_WORD, 0, 32'h14, 32'h0);
        step();
        check("rst_first_gnt", obs_gnt, 2'b01);
        put(0, 0, 0, ACC_WORD, 0, 32'h10, 32'h0);
        put(1, 0, 0, ACC_WORD, 0, 32'h14, 32'h0);
        rst_i = 1'b1;
        step();
        check("rst_rd_drop", obs_rvalid, 2'b00);
        rst_i = 1'b0;
        step();
        check("rst_rd_after", obs_rvalid, 2'b00);

        // Read then pending write: one bubble before the write is granted.
        put(0, 1, 0, ACC_WORD, 0, 32'h10, 32'h0);
        put(1, 1, 1, ACC_WORD, 0, 32'h44, 32'h600DD00D);
        step();
        check("bub_gnt_n", obs_gnt, 2'b01);
        put(0, 0, 0, ACC_WORD, 0, 32'h10, 32'h0);
        step();
        check("bub_gnt_n1", obs_gnt, 2'b00);
        step();
        check("bub_gnt_n2", obs_gnt, 2'b10);
        put(1, 0, 0, ACC_WORD, 0, 32'h44, 32'h0);
        step();

        // Continuous contention: grants alternate starting with fetch.
        put(0, 1, 0, ACC_WORD, 0, 32'h18, 32'h0);
        put(1, 1, 0, ACC_WORD, 0, 32'h1C, 32'h0);
        for (int c = 0; c < 4; c++) begin
            step();
            check("cont_gnt", obs_gnt, (c % 2 == 0) ? 2'b01 : 2'b10);
        end
        put(0, 0, 0, ACC_WORD, 0, 32'h18, 32'h0);
        put(1, 0, 0, ACC_WORD, 0, 32'h1C, 32'h0);
        step();

        // Randomized traffic; each port holds its request until granted.
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_i[p] && ($urandom_range(0, 99) < 55)) begin
                    acc = 2'($urandom_range(0, 2));
                    ad  = 32'($urandom_range(0, MEM_BYTES - 1));
                    if (acc == ACC_HALF) ad[0] = 1'b0;
                    if (acc == ACC_WORD) ad[1:0] = 2'b00;
                    if ($urandom_range(0, 15) == 0) ad = ad + 32'h1000;
                    put(p, 1'b1, ($urandom_range(0, 2) == 0), acc, 1'($urandom_range(0, 1)),
                        ad, $urandom);
                end
            end
            mc_wr_ready_i = ($urandom_range(0, 7) != 0);
            rst_i = ($urandom_range(0, 249) == 0);
            step();
            for (int p = 0; p < 2; p++) begin
                if (obs_gnt[p]) req_i[p] = 1'b0;
            end
        end
        rst_i = 1'b0;
        req_i = 2'b00;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
